// File: rtl/timer_pkg.sv
// Shared constants, FSM encoding and vector helpers for the timer interrupt arbiter.
package timer_pkg;

  localparam int KIND_CMIA    = 0;
  localparam int KIND_CMIB    = 1;
  localparam int KIND_OVI     = 2;
  localparam int KINDS_PER_CH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  function automatic int vec_encode(input int ch, input int kind);
    return KINDS_PER_CH * ch + kind;
  endfunction

  function automatic int ch_of(input int vec);
    return vec / KINDS_PER_CH;
  endfunction

endpackage

// File: rtl/timer_irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt source plus a rising-edge detector.
module timer_irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is only a history flop; a held level produces a single pulse
  assign rise = s2 & ~s3;

endmodule

// File: rtl/timer_irq_arbiter.sv
// Collects CMIA/CMIB/OVI events of all timer channels and hands them to the CPU one vector at a time.
//   state | meaning
//   IDLE  | no request outstanding; grant the scan winner when anything is eligible
//   REQ   | irq_req high with irq_vec frozen, waiting for irq_ack
module timer_irq_arbiter
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int N_SRC = 3 * N_CH,
  parameter int VEC_W = 4,
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  src_cmia,
  input  logic [N_CH-1:0]  src_cmib,
  input  logic [N_CH-1:0]  src_ovi,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pend_q,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack
);

  localparam int RR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SRC_IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] src_all, rise_all, eligible, clr, pend_d;
  logic [RR_W-1:0]  rr_ptr, rr_d;
  logic [VEC_W-1:0] win_vec, vec_d;
  logic             found, req_d;
  irq_state_e       state, state_d;
  int               start, ch;

  for (genvar c = 0; c < N_CH; c++) begin : g_map
    assign src_all[KINDS_PER_CH*c + KIND_CMIA] = src_cmia[c];
    assign src_all[KINDS_PER_CH*c + KIND_CMIB] = src_cmib[c];
    assign src_all[KINDS_PER_CH*c + KIND_OVI]  = src_ovi[c];
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    timer_irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .src  (src_all[i]),
      .rise (rise_all[i])
    );
  end

  assign eligible = pend_q & mask_q;

  // Channel scan from rr_ptr, CMIA > CMIB > OVI inside the first channel with work
  always_comb begin
    found   = 1'b0;
    win_vec = '0;
    start   = (RR_EN != 0) ? int'(rr_ptr) : 0;
    ch      = 0;
    for (int off = 0; off < N_CH; off++) begin
      ch = start + off;
      if (ch >= N_CH) ch = ch - N_CH;
      for (int k = 0; k < KINDS_PER_CH; k++) begin
        if (!found && eligible[SRC_IW'(vec_encode(ch, k))]) begin
          found   = 1'b1;
          win_vec = VEC_W'(vec_encode(ch, k));
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    req_d   = irq_req;
    vec_d   = irq_vec;
    rr_d    = rr_ptr;
    clr     = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          vec_d   = win_vec;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          clr     = N_SRC'(1) << irq_vec;
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (RR_EN != 0) rr_d = RR_W'((ch_of(int'(irq_vec)) + 1) % N_CH);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge in the ack cycle re-sets the flag, so the event survives the clear
  assign pend_d = (pend_q & ~clr) | rise_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
      rr_ptr  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      state   <= state_d;
      irq_req <= req_d;
      irq_vec <= vec_d;
      rr_ptr  <= rr_d;
      pend_q  <= pend_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_timer_irq_arbiter.sv
// Scoreboard bench: stimulus pushes expected grant vectors, a monitor pops them on each new irq_req.
module tb_timer_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] src_bits;
  logic [3:0]  src_cmia, src_cmib, src_ovi;
  logic        mask_we, mask_we_fp;
  logic [11:0] mask_wdata;
  logic        ack, ack_fp;
  logic [11:0] mask_q, pend_q, mask_q_fp, pend_q_fp;
  logic        irq_req, irq_req_fp;
  logic [3:0]  irq_vec, irq_vec_fp;

  int passed = 0;
  int total  = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      src_cmia[c] = src_bits[3*c];
      src_cmib[c] = src_bits[3*c+1];
      src_ovi[c]  = src_bits[3*c+2];
    end
  end

  timer_irq_arbiter dut (
    .clk(clk), .rst(rst), .src_cmia(src_cmia), .src_cmib(src_cmib), .src_ovi(src_ovi),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_q(mask_q), .pend_q(pend_q),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(ack)
  );

  timer_irq_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst), .src_cmia(src_cmia), .src_cmib(src_cmib), .src_ovi(src_ovi),
    .mask_we(mask_we_fp), .mask_wdata(mask_wdata), .mask_q(mask_q_fp), .pend_q(pend_q_fp),
    .irq_req(irq_req_fp), .irq_vec(irq_vec_fp), .irq_ack(ack_fp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arbitration rule: channels from rr upward, CMIA > CMIB > OVI within a channel
  function automatic int pick(input bit [11:0] e, input int rr);
    int ch;
    for (int off = 0; off < 4; off++) begin
      ch = (rr + off) % 4;
      for (int k = 0; k < 3; k++) if (e[3*ch+k]) return 3*ch + k;
    end
    return -1;
  endfunction

  initial begin : monitor
    bit prev = 1'b0;
    int exp;
    forever begin
      @(posedge clk);
      #1;
      if (irq_req && !prev) begin
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL sb_underflow: unexpected grant vec=%0d at %0t", irq_vec, $time);
        end else begin
          exp = sb_q.pop_front();
          chk("grant_vec", irq_vec, exp);
        end
      end
      prev = irq_req;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_mask(input logic [11:0] m);
    @(negedge clk); mask_wdata = m; mask_we = 1'b1; mask_we_fp = 1'b1;
    @(negedge clk); mask_we = 1'b0; mask_we_fp = 1'b0;
  endtask

  task automatic pulse(input logic [11:0] b);
    @(negedge clk); src_bits = src_bits | b;
    @(negedge clk); src_bits = src_bits & ~b;
  endtask

  task automatic wait_req(input bit fp);
    int n = 0;
    while (!(fp ? irq_req_fp : irq_req) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(fp ? "req_seen_fp" : "req_seen", fp ? irq_req_fp : irq_req, 1);
  endtask

  task automatic do_ack(input bit fp, input int dly);
    wait_req(fp);
    repeat (dly) @(negedge clk);
    if (fp) ack_fp = 1'b1; else ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; ack_fp = 1'b0;
  endtask

  // The re-fired edge lands on pend in the same cycle the ack clears it
  task automatic ack_refire(input bit fp, input logic [11:0] b);
    wait_req(fp);
    src_bits = src_bits | b;
    @(negedge clk); src_bits = src_bits & ~b;
    @(negedge clk); if (fp) ack_fp = 1'b1; else ack = 1'b1;
    @(negedge clk); ack = 1'b0; ack_fp = 1'b0;
  endtask

  initial begin : stim
    bit          any_req;
    bit   [11:0] m_pend, nm, pl, oe;
    int          m_rr, w, exp_n;
    int          fp_exp[4] = '{0, 0, 0, 6};

    rst = 1'b1; src_bits = '0; mask_we = 0; mask_we_fp = 0; mask_wdata = '0; ack = 0; ack_fp = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mask", mask_q, 0);
    chk("rst_pend", pend_q, 0);
    chk("rst_req", irq_req, 0);
    chk("rst_vec", irq_vec, 0);

    // reset in the middle of a handshake
    set_mask(12'hFFF);
    sb_q.push_back(4);
    pulse(12'h010);
    wait_req(0);
    chk("midreq_pend", pend_q, 12'h010);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_req", irq_req, 0);
    chk("async_rst_pend", pend_q, 0);
    chk("async_rst_mask", mask_q, 0);
    @(negedge clk); rst = 1'b0;
    any_req = 0;
    repeat (10) begin @(negedge clk); any_req |= irq_req; end
    chk("post_rst_no_req", any_req, 0);

    // latency from source edge to pend and to request
    set_mask(12'hFFF);
    sb_q.push_back(0);
    @(negedge clk); src_bits[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; chk("lat_pend_k1", pend_q, 0);
    @(posedge clk); #1; chk("lat_pend_k2", pend_q, 12'h001); chk("lat_req_k2", irq_req, 0);
    @(posedge clk); #1; chk("lat_req_k3", irq_req, 1);
    @(negedge clk); src_bits[0] = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("lat_ack_pend", pend_q, 0);
    chk("lat_ack_req", irq_req, 0);

    // kind priority inside one channel, one idle cycle between grants
    sb_q.push_back(3); sb_q.push_back(4); sb_q.push_back(5);
    pulse(12'h038);
    for (int i = 0; i < 3; i++) begin
      wait_req(0);
      ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      chk("prio_gap_low", irq_req, 0);
      if (i < 2) begin
        @(posedge clk); #1;
        chk("prio_regrant", irq_req, 1);
        @(negedge clk);
      end
    end

    // round-robin between channel 0 and channel 2
    do_reset();
    set_mask(12'hFFF);
    sb_q.push_back(0); sb_q.push_back(6); sb_q.push_back(0); sb_q.push_back(6);
    pulse(12'h041);
    ack_refire(0, 12'h001);
    ack_refire(0, 12'h040);
    do_ack(0, 0);
    do_ack(0, 0);

    // fixed priority instance: channel 0 keeps winning while it re-fires
    do_reset();
    set_mask(12'hFFF);
    sb_q.push_back(0);
    pulse(12'h041);
    for (int i = 0; i < 4; i++) begin
      wait_req(1);
      chk("fp_vec", irq_vec_fp, fp_exp[i]);
      if (i < 2) ack_refire(1, 12'h001);
      else do_ack(1, 0);
    end

    // edge coincident with the ack keeps its pending flag
    do_reset();
    set_mask(12'hFFF);
    sb_q.push_back(7); sb_q.push_back(7);
    pulse(12'h080);
    ack_refire(0, 12'h080);
    chk("setclr_pend", pend_q, 12'h080);
    do_ack(0, 0);
    @(negedge clk);
    chk("setclr_final_pend", pend_q, 0);

    // masked level source: pends once, granted only after unmask, no re-trigger
    do_reset();
    @(negedge clk); src_bits[11] = 1'b1;
    any_req = 0;
    repeat (50) begin @(negedge clk); any_req |= irq_req; end
    chk("mask_pend", pend_q, 12'h800);
    chk("mask_no_req", any_req, 0);
    sb_q.push_back(11);
    set_mask(12'h800);
    do_ack(0, 1);
    any_req = 0;
    repeat (10) begin @(negedge clk); any_req |= irq_req; end
    chk("level_no_retrig", any_req, 0);
    chk("level_pend", pend_q, 0);
    src_bits[11] = 1'b0;

    // randomized rounds against the reference model
    do_reset();
    m_pend = '0; m_rr = 0;
    for (int r = 0; r < 40; r++) begin
      nm = 12'($urandom_range(0, 4095));
      pl = 12'($urandom & $urandom);
      exp_n = 0;
      oe = m_pend & nm;
      if (oe != 0) begin
        w = pick(oe, m_rr);
        sb_q.push_back(w); exp_n++;
        m_pend = m_pend | pl;
        m_pend[w] = 1'b0;
        m_rr = (w / 3 + 1) % 4;
      end else begin
        m_pend = m_pend | pl;
      end
      while ((m_pend & nm) != 0) begin
        w = pick(m_pend & nm, m_rr);
        sb_q.push_back(w); exp_n++;
        m_pend[w] = 1'b0;
        m_rr = (w / 3 + 1) % 4;
      end
      set_mask(nm);
      pulse(pl);
      repeat (3) @(negedge clk);
      for (int i = 0; i < exp_n; i++) do_ack(0, $urandom_range(0, 2));
      repeat (4) @(negedge clk);
      chk("rnd_idle", irq_req, 0);
      chk("rnd_pend", pend_q, m_pend);
      chk("rnd_mask", mask_q, nm);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
